// File: rtl/fir_coef_loader_if.sv
// fir_coef_loader_if: load handshake and serial shift-chain signals of the coefficient loader
interface fir_coef_loader_if #(
    parameter int NTAPS = 4,
    parameter int CW    = 8
);
    localparam int NB = NTAPS * CW;
    localparam int BW = $clog2(NB + 1);
    logic [NB-1:0] coef_in;
    logic          load_valid;
    logic          load_ready;
    logic          shiftIn;
    logic          shiftClkEn;
    logic          busy;
    logic          done;
    logic [BW-1:0] bit_idx;
    modport master (
        output coef_in, load_valid,
        input  load_ready, shiftIn, shiftClkEn, busy, done, bit_idx
    );
    modport slave (
        input  coef_in, load_valid,
        output load_ready, shiftIn, shiftClkEn, busy, done, bit_idx
    );
endinterface

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: serializes a parallel FIR coefficient set MSB-first onto a gated shift chain
module fir_coef_loader #(
    parameter int NTAPS  = 4,
    parameter int CW     = 8,
    parameter int SETTLE = 2
) (
    input logic           ph1,
    input logic           resetb,
    fir_coef_loader_if.slave bus
);
    localparam int NB = NTAPS * CW;
    localparam int BW = $clog2(NB + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SETL  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [NB-1:0] shadow_q, shadow_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          shift_in_q, shift_in_d;
    logic          clk_en_q, clk_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    assign bus.load_ready = (state_q == IDLE);
    assign bus.shiftIn    = shift_in_q;
    assign bus.shiftClkEn = clk_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bit_idx    = bit_idx_q;

    // Next-state logic; the shadow holds the bits not yet presented, so the first bit goes out on the accept edge
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        bit_idx_d  = bit_idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        shift_in_d = 1'b0;
        clk_en_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (bus.load_valid) begin
                shadow_d   = bus.coef_in << 1;
                shift_in_d = bus.coef_in[NB-1];
                clk_en_d   = 1'b1;
                busy_d     = 1'b1;
                bit_idx_d  = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == BW'(NB - 1)) begin
                    cnt_d   = '0;
                    state_d = (SETTLE == 0) ? DONE : SETL;
                    done_d  = (SETTLE == 0);
                end else begin
                    shift_in_d = shadow_q[NB-1];
                    shadow_d   = shadow_q << 1;
                    clk_en_d   = 1'b1;
                end
            end
            SETL: begin
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_q) == SETTLE - 1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the shift enable without waiting for a clock
    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            shift_in_q <= 1'b0;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            shift_in_q <= shift_in_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: table-driven and randomized checks of the coefficient loader against a timeline model
module tb_fir_coef_loader;
    localparam int NT = 4, CW = 8, NB = 32, S = 2, L = NB + S + 1, BW = $clog2(NB + 1);

    logic ph1 = 1'b0;
    logic resetb = 1'b0;
    fir_coef_loader_if #(.NTAPS(NT), .CW(CW)) bus ();
    fir_coef_loader_if #(.NTAPS(NT), .CW(CW)) bus0 ();

    fir_coef_loader #(.NTAPS(NT), .CW(CW), .SETTLE(S)) dut (.ph1(ph1), .resetb(resetb), .bus(bus));
    fir_coef_loader #(.NTAPS(NT), .CW(CW), .SETTLE(0)) dut0 (.ph1(ph1), .resetb(resetb), .bus(bus0));

    always #5 ph1 = ~ph1;

    int pass_n = 0, total_n = 0;
    int cur = 0, acc = 0;
    bit have = 1'b0;
    logic [NB-1:0] word = '0;
    logic [NB-1:0] chain = '0;
    int en_cnt = 0, busy_cnt = 0, done_cnt = 0;

    // Filter-side chain: captures on the ph2 phase of each enabled cycle
    always @(negedge ph1) begin
        if (bus.shiftClkEn) chain <= {chain[NB-2:0], bus.shiftIn};
        if (bus.shiftClkEn) en_cnt <= en_cnt + 1;
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total_n++;
        if (a === e) pass_n++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    endtask

    // Expected {ready, en, shiftIn, busy, done, bit_idx} from the cycle offset since the last accept
    function automatic logic [10:0] model();
        int k = cur - acc;
        logic [BW-1:0] ix = have ? BW'(NB) : '0;
        if (!have || k <= 0 || k > L) return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ix};
        if (k <= NB) return {1'b0, 1'b1, word[NB-k], 1'b1, 1'b0, BW'(k - 1)};
        if (k < L) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, BW'(NB)};
        return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, BW'(NB)};
    endfunction

    task automatic step(input logic v, input logic [NB-1:0] c);
        logic [10:0] e;
        bus.load_valid = v;
        bus.coef_in = c;
        e = model();
        chk("cycle", 32'({bus.load_ready, bus.shiftClkEn, bus.shiftIn, bus.busy, bus.done, bus.bit_idx}), 32'(e));
        if (v && e[10]) begin
            have = 1'b1;
            acc = cur;
            word = c;
        end
        @(negedge ph1);
        cur++;
    endtask

    typedef struct {
        logic [NB-1:0] coef;
        logic [NB-1:0] chain;
        int            ens;
        int            busy;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int last_k, last_bit, done_k, en0;
        tbl[0] = '{32'h04030201, 32'h04030201, 32, 35};
        tbl[1] = '{32'hFF00A55A, 32'hFF00A55A, 32, 35};
        tbl[2] = '{32'h80000001, 32'h80000001, 32, 35};
        bus.load_valid = 1'b0;
        bus.coef_in = '0;
        bus0.load_valid = 1'b0;
        bus0.coef_in = '0;
        repeat (2) @(negedge ph1);
        chk("reset_outs", 32'({bus.shiftClkEn, bus.shiftIn, bus.busy, bus.done, bus.bit_idx}), 32'd0);
        resetb = 1'b1;
        repeat (2) step(1'b0, $urandom);

        for (int i = 0; i < 3; i++) begin
            en_cnt = 0; busy_cnt = 0; done_cnt = 0;
            step(1'b1, tbl[i].coef);
            repeat (39) step(1'b0, $urandom);
            chk("chain", chain, tbl[i].chain);
            chk("en_count", en_cnt, tbl[i].ens);
            chk("busy_count", busy_cnt, tbl[i].busy);
            chk("done_count", done_cnt, 1);
        end

        en_cnt = 0; done_cnt = 0;
        step(1'b1, 32'h13579BDF);
        repeat (10) step(1'b0, 32'h13579BDF);
        chk("ready_while_shift", bus.load_ready, 1'b0);
        step(1'b1, 32'hDEADBEEF);
        repeat (30) step(1'b0, 32'hDEADBEEF);
        chk("ignored_chain", chain, 32'h13579BDF);
        chk("ignored_done", done_cnt, 1);

        en_cnt = 0; done_cnt = 0;
        repeat (108) step(1'b1, $urandom);
        repeat (40) step(1'b0, $urandom);
        chk("b2b_en_count", en_cnt, 96);
        chk("b2b_done_count", done_cnt, 3);

        step(1'b1, 32'hA5A5F00F);
        repeat (17) step(1'b0, $urandom);
        resetb = 1'b0;
        #1;
        chk("rst_en_async", bus.shiftClkEn, 1'b0);
        chk("rst_busy_async", bus.busy, 1'b0);
        @(negedge ph1);
        resetb = 1'b1;
        have = 1'b0;
        repeat (2) step(1'b0, $urandom);
        en_cnt = 0; done_cnt = 0;
        step(1'b1, 32'h01020304);
        repeat (39) step(1'b0, $urandom);
        chk("post_rst_chain", chain, 32'h01020304);
        chk("post_rst_en_count", en_cnt, 32);

        repeat (6) begin
            repeat ($urandom_range(0, 3)) step(1'b0, $urandom);
            repeat (45) step(($urandom % 4) == 0, $urandom);
        end
        repeat (40) step(1'b0, $urandom);

        chk("s0_ready", bus0.load_ready, 1'b1);
        bus0.coef_in = 32'h00000001;
        bus0.load_valid = 1'b1;
        @(negedge ph1);
        bus0.load_valid = 1'b0;
        last_k = 0; last_bit = 0; done_k = 0; en0 = 0;
        for (int k = 1; k <= 36; k++) begin
            if (bus0.shiftClkEn) begin
                last_k = k;
                last_bit = int'(bus0.shiftIn);
                en0++;
            end
            if (bus0.done) done_k = k;
            @(negedge ph1);
        end
        chk("s0_last_bit_cycle", last_k, 32);
        chk("s0_last_bit", last_bit, 1);
        chk("s0_done_cycle", done_k, 33);
        chk("s0_en_count", en0, 32);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Transmit side of the FIR coefficient shift-chain interface.
- Accepts one parallel coefficient set c0..c3 on a valid/ready handshake and serializes it onto shiftIn with a per-bit enable shiftClkEn.
- Board/top logic gates shiftClkEn with ph1/ph2 to form shiftClk1/shiftClk2 for the filter datapath's coefficient chain.
- Asserts busy while shifting so the sample feed can be held off, and pulses done once the chain is settled.

Parameters:
- NTAPS, 4, number of coefficients in the chain.
- CW, 8, bits per coefficient.
- SETTLE, 2, idle cycles after the last shifted bit before done.

Ports:
- ph1  input  1  sole clock; all state updates on rising edge.
- resetb  input  1  asynchronous, active-low reset.
- coef_in  input  NTAPS*CW  packed set: c0 = bits[CW-1:0], c3 = top CW bits.
- load_valid  input  1  request to transmit coef_in.
- load_ready  output  1  high only in IDLE; handshake completes when valid & ready.
- shiftIn  output  1  serial coefficient bit.
- shiftClkEn  output  1  high for exactly one cycle per transmitted bit.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle pulse when load complete.
- bit_idx  output  clog2(NTAPS*CW+1)  bits already shifted (debug/verification).

Behaviour:
- Reset, asynchronous on resetb low:
  - State IDLE.
  - shiftIn=0, shiftClkEn=0, busy=0, done=0, bit_idx=0.
  - Shadow register cleared.
  - load_ready=1 from the first edge after release.
- States:
  - IDLE: load_ready=1. On load_valid=1, capture coef_in into the shadow register, bit_idx=0, busy=1 -> SHIFT.
  - SHIFT: each cycle drive shiftIn = shadow MSB, shiftClkEn=1, shift shadow left by 1, bit_idx+1. After NTAPS*CW bits -> SETTLE.
  - SETTLE: shiftClkEn=0, shiftIn=0. Count SETTLE cycles, then -> DONE. SETTLE=0 goes straight to DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Bit order:
  - Most significant bit of the packed word first, i.e. c3 MSB first, c0 LSB last.
  - After the full load, c0 sits nearest the chain input stage and c3 at the far end.
- Latency:
  - Handshake cycle N -> first shiftClkEn at cycle N+1.
  - Last bit at N+NTAPS*CW.
  - done at N+NTAPS*CW+SETTLE+1.
  - With defaults: 32 enabled cycles, done at N+35.
- shiftIn and shiftClkEn are both registered and change on the same ph1 edge. shiftIn is stable for the whole cycle in which shiftClkEn=1, so the ph2-gated capture in the filter sees a settled bit.
- shiftClkEn is never high outside SHIFT. There are no gaps between bits within one load.
- load_valid while not IDLE: ignored, no capture. coef_in changes after accept do not affect the in-flight load.
- load_valid held high through DONE: the next load is accepted in the IDLE cycle after done, giving at least one idle cycle between loads.
- resetb asserted mid-SHIFT: shiftClkEn drops immediately (asynchronous). The partial load is abandoned and not resumed; the filter chain content is undefined until the next full load.
- bit_idx saturates at NTAPS*CW through SETTLE/DONE and clears on the next accept.

Test Plan:
- Reset then load coef_in=0x04030201 -> shiftIn over the 32 enabled cycles = 00000100 00000011 00000010 00000001; done at accept+35; busy high for exactly 35 cycles.
- Load 0xFF00A55A -> exactly 32 shiftClkEn cycles. A bench shift register captured at the ph2-gated clock equals 0xFF00A55A (c0=0x5A, c1=0xA5, c2=0x00, c3=0xFF).
- load_valid pulsed at bit 10 of an active load with different coef_in -> ignored; load_ready=0; stream unchanged; only one done pulse.
- load_valid held high continuously -> back-to-back loads, each 32 bits, one idle cycle between done and the next first bit; no shiftClkEn during SETTLE.
- resetb low at bit 17 -> shiftClkEn=0 and busy=0 without waiting for a clock edge. A fresh load of 0x01020304 after release yields the full 32-bit stream from bit 0.
- Instance with SETTLE=0 and load 0x00000001 -> last bit 1 in cycle accept+32, done at accept+33.
